mem_burst_ram: RTL and testbench
================================

Name: mem_burst_ram

Overview:
Parametrised, synthesisable memory-side responder for the ddr3_axi_ctrl mem_* request/data interface. It replaces the fixed 4-beat, 32-bit fake SDRAM with a block RAM model that supports configurable width, depth, burst length and read latency. It flags misaligned requests, simultaneous store/fetch and overlong write bursts on an error output instead of stopping simulation. It sits directly below ddr3_axi_ctrl in benches and FPGA bring-up builds, standing in for the DDR3 PHY.

Parameters:
WIDTH, 32, data bus width in bits (multiple of 8)
MASKS, WIDTH/8, byte-lane count
ADDRS, 32, mem_addr_i width (byte address)
DBITS, 10, log2 of RAM depth in words
BURST, 4, beats per fetch; expected beats per store
REQID, 4, request/response ID width
RD_LAT, 2, cycles from fetch accept to first rdvalid (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  async active-low reset
mem_store_i  in  1  write request
mem_fetch_i  in  1  read request
mem_accept_o  out  1  request accepted when high with store/fetch
mem_error_o  out  1  one-cycle error pulse
mem_req_id_i  in  REQID  request ID
mem_addr_i  in  ADDRS  byte address
mem_wrvalid_i  in  1  write beat valid
mem_wrready_o  out  1  write beat ready
mem_wrlast_i  in  1  final write beat
mem_wrmask_i  in  MASKS  byte enables
mem_wrdata_i  in  WIDTH  write data
mem_rdvalid_o  out  1  read beat valid
mem_rdready_i  in  1  read beat ready
mem_rdlast_o  out  1  final read beat
mem_resp_id_o  out  REQID  ID of read in flight
mem_rddata_o  out  WIDTH  read data

Behaviour:
- Reset (async, reset_n low): state IDLE. accept, error, wrready, rdvalid and rdlast are all 0. resp_id and rddata are 0. RAM contents are not reset.
- Word address = mem_addr_i[DBITS+LSB-1:LSB], where LSB = log2(MASKS). Higher bits are ignored, so the address aliases modulo depth.
- FSM states: IDLE, WRITE, RDWAIT, READ.
- accept_o is registered. It is 1 only in IDLE, and drops to 0 the cycle after a request is accepted.
- IDLE, (store|fetch) & accept:
  - store: go to WRITE with wrready=1 next cycle.
  - fetch: latch req_id into resp_id_o, load the latency counter with RD_LAT-1, go to RDWAIT.
  - store & fetch together: store wins, fetch is ignored, error pulses.
- Misaligned address (addr[LSB-1:0] != 0): LSBs are truncated, the transfer proceeds, and error pulses 1 cycle after accept.
- WRITE:
  - Each wrvalid & wrready beat writes the bytes enabled by wrmask to RAM[waddr], then increments waddr (wraps at depth).
  - A beat with wrlast ends the burst: wrready=0 and state IDLE next cycle, so accept=1 one cycle later.
  - Beats counted beyond BURST are still written, and error pulses once per extra beat.
- RDWAIT: counts down to 0, then READ with rdvalid=1. First valid data appears exactly RD_LAT+1 cycles after the accept edge.
- READ:
  - rddata is registered from RAM[raddr].
  - On rdvalid & rdready: advance raddr and beat count; the next data is valid the following cycle with no bubble.
  - rdlast=1 on beat BURST.
  - rdvalid, rddata, rdlast and resp_id hold stable while rdready=0.
  - The rdlast handshake returns the FSM to IDLE, with rdvalid=0 and resp_id=0 next cycle.
- Read-during-write cannot occur (single-issue FSM).
- Reset asserted mid-burst aborts immediately. Partially written data remains; no further beats are accepted.

Optional Feature:
MEM_WRAP_BURST_EN
- Defined: fetch and store addresses wrap within a BURST-word aligned window, critical-word-first. Example with BURST=4, start word 6: sequence is 6,7,4,5. Requires BURST to be a power of 2.
- Undefined: linear increment, wrapping only at 2^DBITS.

Test Plan:
- Store addr 0x000, 4 beats 0x11111111..0x44444444, mask 0xF, then fetch addr 0 ID 3 -> rddata 0x11111111,0x22222222,0x33333333,0x44444444; rdlast on beat 4; resp_id=3; first rdvalid 3 cycles after accept (RD_LAT=2).
- Store addr 0x010, mask 0x5, data 0xAABBCCDD over preloaded 0 -> fetch returns 0x00BB00DD at word 4.
- Fetch with rdready toggled 1,0,0,1,... -> data/rdlast held during stalls, beat order intact, no duplicates.
- Store addr 0x3FC (word 255, DBITS=8), 4 beats -> words 255,0,1,2 written (linear); with MEM_WRAP_BURST_EN -> words 255,252,253,254.
- Fetch addr 0x002 -> error pulse 1 cycle, data from word 0; store+fetch same cycle -> store served, error pulse.
- Drive reset_n low mid-read on beat 2 -> rdvalid=0, accept=0 immediately; after release accept=1 and a new fetch completes normally.

Source files
------------

// File: rtl/mem_burst_ram.sv
// rtl/mem_burst_ram.sv - block-RAM memory responder for the ddr3_axi_ctrl mem_* interface
//
// Answers store/fetch bursts from a byte-maskable block RAM with a
// configurable read latency. Misaligned addresses, simultaneous store and
// fetch, and write beats beyond BURST are reported on mem_error_o as a
// one-cycle pulse; the transfer still completes.
//
// Optional build macro: MEM_WRAP_BURST_EN
//   defined   - burst addresses wrap inside a BURST-word aligned window,
//               critical word first (BURST must be a power of two)
//   undefined - burst addresses increment linearly, wrapping at 2^DBITS
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   mem_store_i/fetch_i   write / read request
//   mem_accept_o          registered; request taken when high with store/fetch
//   mem_error_o           one-cycle error pulse
//   mem_req_id_i          request ID, echoed on mem_resp_id_o for reads
//   mem_addr_i            byte address (word = addr[DBITS+LSB-1:LSB])
//   mem_wr*               write beat channel (valid/ready/last/mask/data)
//   mem_rd*               read beat channel (valid/ready/last/data) + resp_id
module mem_burst_ram #(
  parameter int WIDTH  = 32,
  parameter int MASKS  = WIDTH / 8,
  parameter int ADDRS  = 32,
  parameter int DBITS  = 10,
  parameter int BURST  = 4,
  parameter int REQID  = 4,
  parameter int RD_LAT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             mem_store_i,
  input  logic             mem_fetch_i,
  output logic             mem_accept_o,
  output logic             mem_error_o,
  input  logic [REQID-1:0] mem_req_id_i,
  input  logic [ADDRS-1:0] mem_addr_i,
  input  logic             mem_wrvalid_i,
  output logic             mem_wrready_o,
  input  logic             mem_wrlast_i,
  input  logic [MASKS-1:0] mem_wrmask_i,
  input  logic [WIDTH-1:0] mem_wrdata_i,
  output logic             mem_rdvalid_o,
  input  logic             mem_rdready_i,
  output logic             mem_rdlast_o,
  output logic [REQID-1:0] mem_resp_id_o,
  output logic [WIDTH-1:0] mem_rddata_o
);

  localparam int LSB   = (MASKS > 1) ? $clog2(MASKS) : 0;
  localparam int DEPTH = 1 << DBITS;
  localparam int BW    = $clog2(BURST + 1) + 1;
  localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDRS-1:0] LSB_MASK = ADDRS'((1 << LSB) - 1);

  typedef enum logic [1:0] {IDLE, WRITE, RDWAIT, READ} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ram [DEPTH];
  logic [DBITS-1:0] ptr;
  logic [BW-1:0]    beat;
  logic [LW-1:0]    lat_cnt;
  logic [ADDRS-1:0] addr_sh;
  logic [DBITS-1:0] start_word;
  logic             unused_addr;
  logic             take, take_fetch, misaligned;
  logic             wr_fire, wr_extra, rd_fire, rd_load;
  logic             accept_d, wrready_d, error_d;

  // Address bits above the RAM depth are dropped, so addresses alias.
  assign addr_sh     = mem_addr_i >> LSB;
  assign start_word  = addr_sh[DBITS-1:0];
  assign unused_addr = ^addr_sh;

  function automatic logic [DBITS-1:0] next_word(input logic [DBITS-1:0] w);
`ifdef MEM_WRAP_BURST_EN
    logic [DBITS-1:0] win;
    win = DBITS'(BURST - 1);
    return (w & ~win) | ((w + DBITS'(1)) & win);
`else
    return w + DBITS'(1);
`endif
  endfunction

  assign take       = mem_accept_o & (mem_store_i | mem_fetch_i);
  assign take_fetch = take & ~mem_store_i;  // store wins a tie
  assign misaligned = |(mem_addr_i & LSB_MASK);
  assign wr_fire    = (state == WRITE) & mem_wrvalid_i & mem_wrready_o;
  assign wr_extra   = (beat >= BW'(BURST));
  assign rd_fire    = mem_rdvalid_o & mem_rdready_i;
  // Load the output register on entry to READ and on every non-final
  // handshake, so beats follow each other without a bubble.
  assign rd_load    = (state == READ) & (~mem_rdvalid_o | (rd_fire & ~mem_rdlast_o));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = mem_store_i ? WRITE : RDWAIT;
      WRITE:   if (wr_fire && mem_wrlast_i) state_nxt = IDLE;
      RDWAIT:  if (lat_cnt == '0) state_nxt = READ;
      READ:    if (rd_fire && mem_rdlast_o) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // Accept stays low for the first IDLE cycle after a burst ends.
    accept_d  = (state == IDLE) & ~take;
    wrready_d = (state_nxt == WRITE);
    error_d   = (take & (misaligned | (mem_store_i & mem_fetch_i))) | (wr_fire & wr_extra);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_accept_o  <= 1'b0;
      mem_error_o   <= 1'b0;
      mem_wrready_o <= 1'b0;
      mem_rdvalid_o <= 1'b0;
      mem_rdlast_o  <= 1'b0;
      mem_resp_id_o <= '0;
      mem_rddata_o  <= '0;
      ptr           <= '0;
      beat          <= '0;
      lat_cnt       <= '0;
    end else begin
      mem_accept_o  <= accept_d;
      mem_wrready_o <= wrready_d;
      mem_error_o   <= error_d;
      if (take) begin
        ptr  <= start_word;
        beat <= '0;
      end
      if (take_fetch) begin
        mem_resp_id_o <= mem_req_id_i;
        lat_cnt       <= LW'(RD_LAT - 1);
      end
      if (state == RDWAIT && lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
      if (wr_fire) begin
        ptr <= next_word(ptr);
        if (!wr_extra) beat <= beat + BW'(1);  // saturates at BURST
      end
      if (rd_load) begin
        mem_rddata_o  <= ram[ptr];
        mem_rdvalid_o <= 1'b1;
        mem_rdlast_o  <= (beat == BW'(BURST - 1));
        ptr           <= next_word(ptr);
        beat          <= beat + BW'(1);
      end else if (rd_fire && mem_rdlast_o) begin
        mem_rdvalid_o <= 1'b0;
        mem_rdlast_o  <= 1'b0;
        mem_resp_id_o <= '0;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int i = 0; i < MASKS; i++) begin
        if (mem_wrmask_i[i]) ram[ptr][8*i +: 8] <= mem_wrdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ram.sv
// tb/tb_mem_burst_ram.sv - directed self-checking bench for mem_burst_ram
module tb_mem_burst_ram;

  logic        clock;
  logic        reset_n;
  logic        mem_store_i, mem_fetch_i, mem_accept_o, mem_error_o;
  logic [3:0]  mem_req_id_i;
  logic [31:0] mem_addr_i;
  logic        mem_wrvalid_i, mem_wrready_o, mem_wrlast_i;
  logic [3:0]  mem_wrmask_i;
  logic [31:0] mem_wrdata_i;
  logic        mem_rdvalid_o, mem_rdready_i, mem_rdlast_o;
  logic [3:0]  mem_resp_id_o;
  logic [31:0] mem_rddata_o;

  int vec, miss;

  logic [31:0] wdata [8];
  logic [31:0] cap_data [8];
  logic        cap_last [8];
  logic [3:0]  cap_id [8];
  int          cap_n, cap_lat, cap_err_n, cap_err_at;
  logic        cap_post_valid;
  logic [3:0]  cap_post_id;
  int          st_err_n, st_err_at;
  logic        st_acc0, st_wrready1, st_post_wrready, st_post_acc0, st_post_acc1;

  mem_burst_ram #(.DBITS(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_store_i(mem_store_i), .mem_fetch_i(mem_fetch_i),
    .mem_accept_o(mem_accept_o), .mem_error_o(mem_error_o),
    .mem_req_id_i(mem_req_id_i), .mem_addr_i(mem_addr_i),
    .mem_wrvalid_i(mem_wrvalid_i), .mem_wrready_o(mem_wrready_o),
    .mem_wrlast_i(mem_wrlast_i), .mem_wrmask_i(mem_wrmask_i),
    .mem_wrdata_i(mem_wrdata_i), .mem_rdvalid_o(mem_rdvalid_o),
    .mem_rdready_i(mem_rdready_i), .mem_rdlast_o(mem_rdlast_o),
    .mem_resp_id_o(mem_resp_id_o), .mem_rddata_o(mem_rddata_o)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cycle counts below are in clock edges after the accepting edge.
  task automatic bus_store(input logic [31:0] addr, input int n, input logic [3:0] mask,
                           input logic both);
    int cyc;
    int t;
    st_err_n = 0; st_err_at = -1;
    @(negedge clock);
    mem_store_i = 1; mem_fetch_i = both; mem_addr_i = addr; mem_req_id_i = 4'hE;
    t = 0;
    while (!mem_accept_o && t < 40) begin @(negedge clock); t++; end
    if (!mem_accept_o) begin
      vec++; miss++;
      $display("FAIL store_accept_timeout: accept=%b, required 1", mem_accept_o);
      mem_store_i = 0; mem_fetch_i = 0;
      return;
    end
    @(negedge clock);
    mem_store_i = 0; mem_fetch_i = 0;
    st_acc0 = mem_accept_o; st_wrready1 = mem_wrready_o;
    cyc = 0;
    if (mem_error_o) begin st_err_n++; st_err_at = 0; end
    for (int i = 0; i < n; i++) begin
      if (!mem_wrready_o) begin
        vec++; miss++;
        $display("FAIL store_wrready_beat%0d: wrready=%b, required 1", i, mem_wrready_o);
        break;
      end
      mem_wrvalid_i = 1; mem_wrdata_i = wdata[i]; mem_wrmask_i = mask;
      mem_wrlast_i = (i == n - 1);
      @(negedge clock); cyc++;
      if (mem_error_o) begin st_err_n++; if (st_err_at < 0) st_err_at = cyc; end
    end
    mem_wrvalid_i = 0; mem_wrlast_i = 0;
    st_post_wrready = mem_wrready_o; st_post_acc0 = mem_accept_o;
    @(negedge clock);
    if (mem_error_o) st_err_n++;
    st_post_acc1 = mem_accept_o;
  endtask

  task automatic bus_fetch(input logic [31:0] addr, input logic [3:0] id);
    int t;
    logic done;
    cap_n = 0; cap_lat = -1; cap_err_n = 0; cap_err_at = -1; done = 0;
    @(negedge clock);
    mem_fetch_i = 1; mem_addr_i = addr; mem_req_id_i = id; mem_rdready_i = 1;
    t = 0;
    while (!mem_accept_o && t < 40) begin @(negedge clock); t++; end
    if (!mem_accept_o) begin
      vec++; miss++;
      $display("FAIL fetch_accept_timeout: accept=%b, required 1", mem_accept_o);
      mem_fetch_i = 0;
      return;
    end
    @(negedge clock);
    mem_fetch_i = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (mem_error_o) begin cap_err_n++; if (cap_err_at < 0) cap_err_at = k; end
      if (mem_rdvalid_o) begin
        if (cap_lat < 0) cap_lat = k;
        cap_data[cap_n] = mem_rddata_o; cap_last[cap_n] = mem_rdlast_o;
        cap_id[cap_n] = mem_resp_id_o;
        cap_n++;
        if (mem_rdlast_o || cap_n == 8) done = 1;
      end
      @(negedge clock);
    end
    cap_post_valid = mem_rdvalid_o; cap_post_id = mem_resp_id_o;
    if (!done) begin
      vec++; miss++;
      $display("FAIL fetch_timeout: beats=%0d, required rdlast", cap_n);
    end
  endtask

  task automatic test_reset;
    vec++; if (mem_accept_o !== 1'b0) begin miss++; $display("FAIL rst_accept: got %b, expected 0", mem_accept_o); end
    vec++; if (mem_error_o !== 1'b0) begin miss++; $display("FAIL rst_error: got %b, expected 0", mem_error_o); end
    vec++; if (mem_wrready_o !== 1'b0) begin miss++; $display("FAIL rst_wrready: got %b, expected 0", mem_wrready_o); end
    vec++; if (mem_rdvalid_o !== 1'b0) begin miss++; $display("FAIL rst_rdvalid: got %b, expected 0", mem_rdvalid_o); end
    vec++; if (mem_rdlast_o !== 1'b0) begin miss++; $display("FAIL rst_rdlast: got %b, expected 0", mem_rdlast_o); end
    vec++; if (mem_resp_id_o !== 4'h0) begin miss++; $display("FAIL rst_resp_id: got %h, expected 0", mem_resp_id_o); end
    vec++; if (mem_rddata_o !== 32'h0) begin miss++; $display("FAIL rst_rddata: got %h, expected 0", mem_rddata_o); end
    reset_n = 1;
    @(negedge clock);
    vec++; if (mem_accept_o !== 1'b1) begin miss++; $display("FAIL rst_release_accept: got %b, expected 1", mem_accept_o); end
  endtask

  task automatic test_burst;
    for (int i = 0; i < 4; i++) wdata[i] = 32'h11111111 * (i + 1);
    bus_store(32'h000, 4, 4'hF, 0);
    vec++; if (st_acc0 !== 1'b0) begin miss++; $display("FAIL wr_accept_drop: got %b, expected 0", st_acc0); end
    vec++; if (st_wrready1 !== 1'b1) begin miss++; $display("FAIL wr_ready_rise: got %b, expected 1", st_wrready1); end
    vec++; if (st_err_n !== 0) begin miss++; $display("FAIL wr_no_error: got %0d pulses, expected 0", st_err_n); end
    vec++; if (st_post_wrready !== 1'b0) begin miss++; $display("FAIL wr_ready_fall: got %b, expected 0", st_post_wrready); end
    vec++; if (st_post_acc0 !== 1'b0) begin miss++; $display("FAIL wr_end_accept0: got %b, expected 0", st_post_acc0); end
    vec++; if (st_post_acc1 !== 1'b1) begin miss++; $display("FAIL wr_end_accept1: got %b, expected 1", st_post_acc1); end
    bus_fetch(32'h000, 4'd3);
    vec++; if (cap_n !== 4) begin miss++; $display("FAIL rd_beats: got %0d, expected 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (cap_data[i] !== 32'h11111111 * (i + 1)) begin miss++; $display("FAIL rd_data%0d: got %h, expected %h", i, cap_data[i], 32'h11111111 * (i + 1)); end
      vec++; if (cap_last[i] !== (i == 3)) begin miss++; $display("FAIL rd_last%0d: got %b, expected %b", i, cap_last[i], i == 3); end
    end
    vec++; if (cap_id[0] !== 4'd3 || cap_id[3] !== 4'd3) begin miss++; $display("FAIL rd_resp_id: got %h/%h, expected 3", cap_id[0], cap_id[3]); end
    vec++; if (cap_lat !== 3) begin miss++; $display("FAIL rd_latency: got %0d, expected 3", cap_lat); end
    vec++; if (cap_err_n !== 0) begin miss++; $display("FAIL rd_no_error: got %0d pulses, expected 0", cap_err_n); end
    vec++; if (cap_post_valid !== 1'b0 || cap_post_id !== 4'h0) begin miss++; $display("FAIL rd_end: rdvalid=%b resp_id=%h, expected 0/0", cap_post_valid, cap_post_id); end
  endtask

  task automatic test_mask;
    for (int i = 0; i < 4; i++) wdata[i] = 32'h0;
    bus_store(32'h010, 4, 4'hF, 0);
    wdata[0] = 32'hAABBCCDD;
    bus_store(32'h010, 1, 4'h5, 0);
    bus_fetch(32'h010, 4'd1);
    vec++; if (cap_data[0] !== 32'h00BB00DD) begin miss++; $display("FAIL mask_word4: got %h, expected 00bb00dd", cap_data[0]); end
    vec++; if (cap_data[1] !== 32'h0) begin miss++; $display("FAIL mask_word5: got %h, expected 0", cap_data[1]); end
  endtask

  task automatic test_stall;
    logic [7:0]  pat;
    logic [31:0] hold_d;
    logic        hold_l, held;
    int          n, j;
    pat = 8'b1110_1001;
    for (int i = 0; i < 4; i++) wdata[i] = 32'hA5000008 + i;
    bus_store(32'h020, 4, 4'hF, 0);
    @(negedge clock);
    mem_fetch_i = 1; mem_addr_i = 32'h020; mem_req_id_i = 4'd9; mem_rdready_i = 0;
    for (int t = 0; t < 40 && !mem_accept_o; t++) @(negedge clock);
    @(negedge clock);
    mem_fetch_i = 0;
    n = 0; j = 0; held = 0; hold_d = 0; hold_l = 0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      if (held) begin
        vec++; if (mem_rdvalid_o !== 1'b1 || mem_rddata_o !== hold_d || mem_rdlast_o !== hold_l) begin
          miss++; $display("FAIL stall_hold: valid=%b data=%h last=%b, expected 1/%h/%b", mem_rdvalid_o, mem_rddata_o, mem_rdlast_o, hold_d, hold_l);
        end
      end
      mem_rdready_i = mem_rdvalid_o ? pat[j % 8] : 1'b0;
      if (mem_rdvalid_o) j++;
      if (mem_rdvalid_o && mem_rdready_i) begin
        vec++; if (mem_rddata_o !== 32'hA5000008 + n || mem_rdlast_o !== (n == 3)) begin
          miss++; $display("FAIL stall_beat%0d: data=%h last=%b, expected %h/%b", n, mem_rddata_o, mem_rdlast_o, 32'hA5000008 + n, n == 3);
        end
        n++; held = 0;
      end else if (mem_rdvalid_o) begin
        held = 1; hold_d = mem_rddata_o; hold_l = mem_rdlast_o;
      end else held = 0;
      @(negedge clock);
    end
    vec++; if (n !== 4 || mem_rdvalid_o !== 1'b0) begin miss++; $display("FAIL stall_end: beats=%0d rdvalid=%b, expected 4/0", n, mem_rdvalid_o); end
    mem_rdready_i = 1;
  endtask

  task automatic test_alias;
    for (int i = 0; i < 4; i++) wdata[i] = 32'hC0000000 + i;
    bus_store(32'h3FC, 4, 4'hF, 0);
    bus_fetch(32'h400, 4'd4);
`ifdef MEM_WRAP_BURST_EN
    vec++; if (cap_data[0] !== 32'h11111111 || cap_data[3] !== 32'h44444444) begin miss++; $display("FAIL alias_low: got %h/%h, expected 11111111/44444444", cap_data[0], cap_data[3]); end
    bus_fetch(32'h3F0, 4'd4);
    vec++; if (cap_data[0] !== 32'hC0000001 || cap_data[2] !== 32'hC0000003 || cap_data[3] !== 32'hC0000000) begin
      miss++; $display("FAIL alias_high: got %h/%h/%h, expected c0000001/c0000003/c0000000", cap_data[0], cap_data[2], cap_data[3]);
    end
`else
    vec++; if (cap_data[0] !== 32'hC0000001 || cap_data[2] !== 32'hC0000003 || cap_data[3] !== 32'h44444444) begin
      miss++; $display("FAIL alias_low: got %h/%h/%h, expected c0000001/c0000003/44444444", cap_data[0], cap_data[2], cap_data[3]);
    end
    bus_fetch(32'h3F0, 4'd4);
    vec++; if (cap_data[3] !== 32'hC0000000) begin miss++; $display("FAIL alias_high: got %h, expected c0000000", cap_data[3]); end
`endif
  endtask

  task automatic test_errors;
    logic [31:0] w0;
`ifdef MEM_WRAP_BURST_EN
    w0 = 32'h11111111;
`else
    w0 = 32'hC0000001;
`endif
    bus_fetch(32'h002, 4'd5);
    vec++; if (cap_err_n !== 1 || cap_err_at !== 0) begin miss++; $display("FAIL misalign_err: pulses=%0d at=%0d, expected 1 at 0", cap_err_n, cap_err_at); end
    vec++; if (cap_data[0] !== w0 || cap_id[0] !== 4'd5) begin miss++; $display("FAIL misalign_data: got %h id %h, expected %h id 5", cap_data[0], cap_id[0], w0); end
    wdata[0] = 32'h5A5A5A5A;
    bus_store(32'h030, 1, 4'hF, 1);
    vec++; if (st_err_n !== 1 || st_err_at !== 0 || st_wrready1 !== 1'b1) begin
      miss++; $display("FAIL both_req: pulses=%0d at=%0d wrready=%b, expected 1 at 0 wrready 1", st_err_n, st_err_at, st_wrready1);
    end
    bus_fetch(32'h030, 4'd6);
    vec++; if (cap_data[0] !== 32'h5A5A5A5A) begin miss++; $display("FAIL both_data: got %h, expected 5a5a5a5a", cap_data[0]); end
    for (int i = 0; i < 5; i++) wdata[i] = 32'hE0000000 + i;
    bus_store(32'h040, 5, 4'hF, 0);
    vec++; if (st_err_n !== 1 || st_err_at !== 5) begin miss++; $display("FAIL overlong_err: pulses=%0d at=%0d, expected 1 at 5", st_err_n, st_err_at); end
`ifdef MEM_WRAP_BURST_EN
    bus_fetch(32'h040, 4'd7);
`else
    bus_fetch(32'h050, 4'd7);
`endif
    vec++; if (cap_data[0] !== 32'hE0000004) begin miss++; $display("FAIL overlong_data: got %h, expected e0000004", cap_data[0]); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    mem_fetch_i = 1; mem_addr_i = 32'h000; mem_req_id_i = 4'd7; mem_rdready_i = 1;
    for (int t = 0; t < 40 && !mem_accept_o; t++) @(negedge clock);
    @(negedge clock);
    mem_fetch_i = 0;
    for (int t = 0; t < 40 && !mem_rdvalid_o; t++) @(negedge clock);
    @(negedge clock);
    vec++; if (mem_rdvalid_o !== 1'b1) begin miss++; $display("FAIL midrst_beat2_valid: got %b, expected 1", mem_rdvalid_o); end
    reset_n = 0;
    #1;
    vec++; if (mem_rdvalid_o !== 1'b0 || mem_accept_o !== 1'b0 || mem_rdlast_o !== 1'b0) begin
      miss++; $display("FAIL midrst_abort: rdvalid=%b accept=%b rdlast=%b, expected 0/0/0", mem_rdvalid_o, mem_accept_o, mem_rdlast_o);
    end
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    vec++; if (mem_accept_o !== 1'b1) begin miss++; $display("FAIL midrst_accept: got %b, expected 1", mem_accept_o); end
    bus_fetch(32'h020, 4'd2);
    vec++; if (cap_n !== 4 || cap_lat !== 3) begin miss++; $display("FAIL midrst_refetch: beats=%0d lat=%0d, expected 4/3", cap_n, cap_lat); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (cap_data[i] !== 32'hA5000008 + i || cap_last[i] !== (i == 3)) begin
        miss++; $display("FAIL midrst_beat%0d: data=%h last=%b, expected %h/%b", i, cap_data[i], cap_last[i], 32'hA5000008 + i, i == 3);
      end
    end
  endtask

  initial begin
    vec = 0; miss = 0;
    clock = 0; reset_n = 0;
    mem_store_i = 0; mem_fetch_i = 0; mem_req_id_i = 0; mem_addr_i = 0;
    mem_wrvalid_i = 0; mem_wrlast_i = 0; mem_wrmask_i = 0; mem_wrdata_i = 0;
    mem_rdready_i = 0;
    repeat (3) @(negedge clock);
    test_reset;
    test_burst;
    test_mask;
    test_stall;
    test_alias;
    test_errors;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
